dir_input_ctrl: RTL and testbench

DIR_INPUT_CTRL -- requirements
Module: dir_input_ctrl

---
 rtl/dir_input_ctrl.sv | 108 ++++++++++
 tb/tb_dir_input_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dir_input_ctrl.sv
// Direction input controller: synchronises and debounces four push-buttons and steers the snake heading.
// Optional macro DIR_REVERSE_BLOCK_EN rejects 180-degree reversals on move_tick.
module dir_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] btn_raw,
    input  logic       move_tick,
    output logic [3:0] direction,
    output logic       dir_changed,
    output logic [3:0] btn_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_RIGHT = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0001;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    db;
    logic [3:0]    db_d;
    logic [CW-1:0] cnt [4];

    logic [3:0] pending;
    logic [3:0] dir_d;
    logic [3:0] winner;
    logic [3:0] opposite;
    logic       req_ok;
    logic       take;

    // Front end: two-flop synchroniser, per-button debounce, rising-edge pulse
    always_ff @(posedge clk) begin
        if (clear) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            db_d      <= '0;
            btn_press <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            db_d      <= db;
            btn_press <= db & ~db_d;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        winner = '0;
        priority case (1'b1)
            btn_press[3]: winner = DIR_UP;
            btn_press[2]: winner = DIR_RIGHT;
            btn_press[1]: winner = DIR_LEFT;
            btn_press[0]: winner = DIR_DOWN;
            default:      winner = '0;
        endcase
    end

    // UP<->DOWN and RIGHT<->LEFT are mirror bit positions
    assign opposite = {direction[0], direction[1], direction[2], direction[3]};

`ifdef DIR_REVERSE_BLOCK_EN
    assign req_ok = (pending != opposite);
`else
    assign req_ok = 1'b1;
`endif

    assign take = move_tick && (pending != '0) && req_ok;

    always_ff @(posedge clk) begin
        if (clear) begin
            direction   <= DIR_UP;
            dir_d       <= DIR_UP;
            dir_changed <= 1'b0;
            pending     <= '0;
        end else begin
            dir_d       <= direction;
            dir_changed <= (direction != dir_d);
            if (take) begin
                direction <= pending;
            end
            // A press landing with move_tick is stored after the tick uses the old request
            if (btn_press != '0) begin
                pending <= winner;
            end else if (move_tick) begin
                pending <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Scoreboard bench for dir_input_ctrl with DEBOUNCE_CYCLES=4.
// Expected presses and heading changes are queued by stimulus and popped by a monitor.
module tb_dir_input_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] btn_raw;
    logic       move_tick;
    logic [3:0] direction;
    logic       dir_changed;
    logic [3:0] btn_press;

`ifdef DIR_REVERSE_BLOCK_EN
    localparam bit BLOCK = 1'b1;
`else
    localparam bit BLOCK = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_press[$];
    logic [3:0] exp_dir[$];
    logic [3:0] m_dir;
    logic [3:0] m_pend;
    bit         mon_on = 1'b0;

    dir_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .clear(clear),
        .btn_raw(btn_raw),
        .move_tick(move_tick),
        .direction(direction),
        .dir_changed(dir_changed),
        .btn_press(btn_press)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] prio(input logic [3:0] m);
        if (m[3]) return 4'b1000;
        if (m[2]) return 4'b0100;
        if (m[1]) return 4'b0010;
        if (m[0]) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] opp(input logic [3:0] d);
        case (d)
            4'b1000: return 4'b0001;
            4'b0001: return 4'b1000;
            4'b0100: return 4'b0010;
            4'b0010: return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic model_tick();
        if (m_pend != 4'b0000) begin
            if (!(BLOCK && m_pend == opp(m_dir)) && m_pend != m_dir) begin
                m_dir = m_pend;
                exp_dir.push_back(m_dir);
            end
            m_pend = 4'b0000;
        end
    endtask

    // Monitor: every output event must match the next queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (btn_press != 4'b0000) begin
                    if (exp_press.size() == 0) begin
                        check("unexpected_press", btn_press, 4'b0000);
                    end else begin
                        check("btn_press", btn_press, exp_press.pop_front());
                    end
                end
                if (dir_changed) begin
                    if (exp_dir.size() == 0) begin
                        check("unexpected_dir_changed", direction, m_dir);
                        if (direction === m_dir) begin
                            errors++;
                            $display("FAIL dir_changed: pulse with no heading change");
                        end
                    end else begin
                        check("dir_changed_dir", direction, exp_dir.pop_front());
                    end
                end
            end
        end
    end

    task automatic press(input logic [3:0] mask, input int bounce);
        exp_press.push_back(mask);
        for (int b = 0; b < bounce; b++) begin
            btn_raw = (b % 2 == 0) ? mask : 4'b0000;
            @(negedge clk);
        end
        btn_raw = mask;
        repeat (10) @(negedge clk);
        m_pend = prio(mask);
        btn_raw = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic tick();
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        model_tick();
        repeat (3) @(negedge clk);
        check("direction_after_tick", direction, m_dir);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        check("clear_direction", direction, 4'b1000);
        check("clear_btn_press", btn_press, 4'b0000);
        check("clear_dir_changed", {3'b000, dir_changed}, 4'b0000);
        clear = 1'b0;
        m_dir  = 4'b1000;
        m_pend = 4'b0000;
        @(negedge clk);
    endtask

    task automatic press_with_tick(input logic [3:0] mask);
        int n = 0;
        exp_press.push_back(mask);
        btn_raw = mask;
        @(negedge clk);
        while (btn_press == 4'b0000 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (btn_press == 4'b0000) begin
            errors++;
            $display("FAIL press_timeout: btn_press %b expected %b", btn_press, mask);
        end
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        model_tick();
        m_pend = prio(mask);
        repeat (3) @(negedge clk);
        check("direction_coincide", direction, m_dir);
        btn_raw = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        clear     = 1'b1;
        btn_raw   = 4'b0000;
        move_tick = 1'b0;
        m_dir     = 4'b1000;
        m_pend    = 4'b0000;
        repeat (3) @(negedge clk);
        // Stimulus during clear must be ignored
        btn_raw   = 4'b1111;
        move_tick = 1'b1;
        repeat (6) @(negedge clk);
        btn_raw   = 4'b0000;
        move_tick = 1'b0;
        do_clear();
        repeat (8) @(negedge clk);
        mon_on = 1'b1;

        press(4'b0001, 0);
        check("hold_no_tick_dir", direction, 4'b1000);
        check("hold_no_tick_chg", {3'b000, dir_changed}, 4'b0000);
        m_pend = 4'b0000;
        do_clear();

        press(4'b0100, 8);
        tick();
        press(4'b1000, 0);
        tick();
        press(4'b0001, 0);
        tick();
        press(4'b0110, 0);
        tick();
        press(4'b1000, 0);
        tick();
        press(4'b0010, 0);
        press_with_tick(4'b0001);
        tick();

        press(4'b0100, 2);
        do_clear();
        tick();

        // Clear mid-debounce while still held: exactly one press afterwards
        exp_press.push_back(4'b0010);
        btn_raw = 4'b0010;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_dir  = 4'b1000;
        m_pend = 4'b0000;
        repeat (12) @(negedge clk);
        m_pend = 4'b0010;
        btn_raw = 4'b0000;
        repeat (10) @(negedge clk);
        tick();

        for (int k = 0; k < 25; k++) begin
            press(4'($urandom_range(1, 15)), 2 * $urandom_range(0, 4));
            if ($urandom_range(0, 2) != 0) tick();
        end
        tick();

        repeat (5) @(negedge clk);
        check("press_queue_drained", 4'(exp_press.size()), 4'd0);
        check("dir_queue_drained", 4'(exp_dir.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
